// File: rtl/converter_fsm_pkg.sv
// -----------------------------------------------------------------------------
// converter_package
// Shared definitions for the RGB->YCbCr converter control FSM:
//   conv_state_t  : FSM state encoding.
//   PIX_PER_BEAT  : pixels per beat for the default 96-bit stream.
//   pix_per_beat(): pixels per beat for a given stream width.
//   beat_count()  : ceil(n_pixels / pixels-per-beat) via shift + OR-reduce.
// -----------------------------------------------------------------------------
package converter_package;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    START      = 3'd2,
    RUN        = 3'd3,
    FINISH     = 3'd4
  } conv_state_t;

  localparam int unsigned PIXEL_BITS           = 24;
  localparam int unsigned DEFAULT_STREAM_WIDTH = 96;
  localparam int unsigned PIX_PER_BEAT         = DEFAULT_STREAM_WIDTH / PIXEL_BITS;

  function automatic int unsigned pix_per_beat(input int unsigned stream_width);
    return stream_width / PIXEL_BITS;
  endfunction

  // Legal stream widths (96/192/384) give 4, 8 or 16 pixels per beat, so the
  // divide reduces to a right shift by 2, 3 or 4.
  function automatic int unsigned beat_shift(input int unsigned stream_width);
    int unsigned sh;
    case (pix_per_beat(stream_width))
      8:       sh = 3;
      16:      sh = 4;
      default: sh = 2;
    endcase
    return sh;
  endfunction

  // Quotient by shift; any nonzero remainder bit adds one partial beat.
  function automatic logic [31:0] beat_count(input logic [31:0] n_pixels,
                                             input int unsigned stream_width);
    int unsigned sh;
    logic [31:0] mask;
    sh   = beat_shift(stream_width);
    mask = (32'd1 << sh) - 32'd1;
    return (n_pixels >> sh) + {31'd0, |(n_pixels & mask)};
  endfunction

endpackage

// File: rtl/hwpe_stream_package.sv
// -----------------------------------------------------------------------------
// hwpe_stream_package
// Streamer control/flag types shared between the converter FSM and the
// source/sink streamers.
//   ctrl_sourcesink_t  : req_start plus the address-generator configuration.
//   flags_sourcesink_t : ready_start / done status reported by a streamer.
// -----------------------------------------------------------------------------
package hwpe_stream_package;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_roll;
    logic [15:0] step;
    logic        loop_outer;
    logic        realign_type;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic             req_start;
    ctrl_addressgen_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

endpackage

// File: rtl/converter_fsm.sv
// -----------------------------------------------------------------------------
// converter_fsm
// Control FSM of the RGB->YCbCr converter. Accepts a job from the register
// file, configures the source (RGB read) and sink (YCbCr write) streamers,
// waits for both to finish and reports the job duration.
//
// Ports
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   clear_i                : synchronous soft clear (returns to IDLE)
//   start_i                : one-cycle job trigger, honoured only in IDLE
//   src_addr_i, dst_addr_i : byte base addresses of RGB / YCbCr buffers
//   n_pixels_i             : 24-bit pixels in the job
//   source_stream_ctrl_o   : source streamer control (req_start + addressgen)
//   source_stream_flags_i  : source streamer flags (ready_start, done)
//   sink_stream_ctrl_o     : sink streamer control
//   sink_stream_flags_i    : sink streamer flags
//   busy_o                 : high in every state except IDLE
//   done_o                 : one-cycle pulse in FINISH
//   cycles_o               : duration of the last completed job
//   state_o                : current FSM state (debug)
//
// Handshake semantics: a streamer raises ready_start while it can accept a
// new transfer; the FSM pulses req_start for exactly one cycle (START) once
// both streamers are ready in the same cycle. Each streamer then pulses (or
// holds) done when its transfer completes; the FSM remembers each done in a
// sticky bit, so the two may arrive in any order. Flags are ignored in any
// state that does not wait for them.
// -----------------------------------------------------------------------------
module converter_fsm
  import converter_package::*;
  import hwpe_stream_package::*;
#(
  parameter int unsigned STREAM_WIDTH = 96,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] n_pixels_i,
  output ctrl_sourcesink_t     source_stream_ctrl_o,
  input  flags_sourcesink_t    source_stream_flags_i,
  output ctrl_sourcesink_t     sink_stream_ctrl_o,
  input  flags_sourcesink_t    sink_stream_flags_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          cycles_o,
  output conv_state_t          state_o
);

  conv_state_t          r_state;
  conv_state_t          w_next_state;

  logic [31:0]          r_src_addr;
  logic [31:0]          r_dst_addr;
  logic [LEN_WIDTH-1:0] r_beats;
  logic                 r_cfg_valid;   // drives feat_length = 1 once a job is latched
  logic                 r_src_done;
  logic                 r_snk_done;
  logic [31:0]          r_cnt;
  logic [31:0]          r_cycles;

  logic [LEN_WIDTH-1:0] w_beats;
  logic                 w_accept;
  logic                 w_src_done;
  logic                 w_snk_done;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_beats  = LEN_WIDTH'(beat_count(32'(n_pixels_i), STREAM_WIDTH));
  assign w_accept = (r_state == IDLE) && start_i && !clear_i;

  // Sticky-or-incoming: a done arriving this cycle counts immediately, so the
  // FSM reaches FINISH in the cycle after the last done is seen.
  assign w_src_done = r_src_done | source_stream_flags_i.done;
  assign w_snk_done = r_snk_done | sink_stream_flags_i.done;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next_state = (w_beats == '0) ? FINISH : WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (source_stream_flags_i.ready_start && sink_stream_flags_i.ready_start) begin
          w_next_state = START;
        end
      end
      START: w_next_state = RUN;
      RUN: begin
        if (w_src_done && w_snk_done) begin
          w_next_state = FINISH;
        end
      end
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    // Soft clear overrides both a new start and any done arriving now.
    if (clear_i) begin
      w_next_state = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Job configuration: latched on an accepted start, held until the next one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src_addr  <= '0;
      r_dst_addr  <= '0;
      r_beats     <= '0;
      r_cfg_valid <= 1'b0;
    end else if (w_accept) begin
      r_src_addr  <= src_addr_i;
      r_dst_addr  <= dst_addr_i;
      r_beats     <= w_beats;
      r_cfg_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky done bits: collected only in RUN, dropped in FINISH or on clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src_done <= 1'b0;
      r_snk_done <= 1'b0;
    end else if (clear_i || (r_state == FINISH)) begin
      r_src_done <= 1'b0;
      r_snk_done <= 1'b0;
    end else if (r_state == RUN) begin
      r_src_done <= w_src_done;
      r_snk_done <= w_snk_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter. START is the first counted cycle (counter restarts there at
  // 0 and counts that cycle), and cycles_o also counts the FINISH cycle, so
  // cycles_o is the job length from START through FINISH inclusive.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_cycles <= '0;
    end else if (clear_i) begin
      r_cnt    <= '0;
    end else begin
      case (r_state)
        WAIT_READY, RUN: r_cnt <= sat_inc(r_cnt);
        START:           r_cnt <= 32'd1;
        FINISH: begin
          r_cnt    <= '0;
          r_cycles <= sat_inc(r_cnt);
        end
        default:         r_cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    source_stream_ctrl_o = '0;
    sink_stream_ctrl_o   = '0;

    source_stream_ctrl_o.req_start                   = (r_state == START);
    source_stream_ctrl_o.addressgen_ctrl.base_addr   = r_src_addr;
    source_stream_ctrl_o.addressgen_ctrl.trans_size  = 32'(r_beats);
    source_stream_ctrl_o.addressgen_ctrl.line_length = 16'(r_beats);
    source_stream_ctrl_o.addressgen_ctrl.feat_length = {15'd0, r_cfg_valid};

    sink_stream_ctrl_o.req_start                     = (r_state == START);
    sink_stream_ctrl_o.addressgen_ctrl.base_addr     = r_dst_addr;
    sink_stream_ctrl_o.addressgen_ctrl.trans_size    = 32'(r_beats);
    sink_stream_ctrl_o.addressgen_ctrl.line_length   = 16'(r_beats);
    sink_stream_ctrl_o.addressgen_ctrl.feat_length   = {15'd0, r_cfg_valid};
  end

  assign busy_o   = (r_state != IDLE);
  assign done_o   = (r_state == FINISH);
  assign cycles_o = r_cycles;
  assign state_o  = r_state;

endmodule

// File: tb/tb_converter_fsm.sv
// -----------------------------------------------------------------------------
// tb_converter_fsm
// Self-checking bench for converter_fsm (default STREAM_WIDTH=96, LEN_WIDTH=16).
// Each job is predicted as a timeline relative to the cycle that presents
// start_i (cycle 0): START follows the first cycle in WAIT_READY where both
// streamers are ready, FINISH follows the later of the two done cycles, and
// the job length runs from START through FINISH inclusive.
// -----------------------------------------------------------------------------
module tb_converter_fsm;
  import hwpe_stream_package::*;
  import converter_package::*;

  localparam int PPB = 96 / 24;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic              start_i;
  logic [31:0]       src_addr_i;
  logic [31:0]       dst_addr_i;
  logic [15:0]       n_pixels_i;
  ctrl_sourcesink_t  src_ctrl;
  flags_sourcesink_t src_flags;
  ctrl_sourcesink_t  snk_ctrl;
  flags_sourcesink_t snk_flags;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       cycles_o;
  conv_state_t       state_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_cycles = 32'd0;

  converter_fsm dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .clear_i               (clear_i),
    .start_i               (start_i),
    .src_addr_i            (src_addr_i),
    .dst_addr_i            (dst_addr_i),
    .n_pixels_i            (n_pixels_i),
    .source_stream_ctrl_o  (src_ctrl),
    .source_stream_flags_i (src_flags),
    .sink_stream_ctrl_o    (snk_ctrl),
    .sink_stream_flags_i   (snk_flags),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .cycles_o              (cycles_o),
    .state_o               (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    clear_i    = 1'b0;
    start_i    = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    n_pixels_i = '0;
    src_flags  = '0;
    snk_flags  = '0;
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Drives one job and checks it against the timeline model.
  // rs/rk: cycles the source/sink keep ready_start low after start_i.
  // sd/kd: cycle (after START) of the source/sink done pulse, >= 1.
  task automatic run_job(input int n, input int rs, input int rk, input int sd,
                         input int kd, input bit restart, input string tag);
    int beats, ts, tf;
    int obs_src_req, obs_snk_req, obs_ts, obs_tf, busy_err;
    logic [31:0] sa, da, exp_cyc, obs_cyc;
    ctrl_addressgen_t exp_src, exp_snk;
    ctrl_addressgen_t obs_src_st, obs_snk_st, obs_src_fin, obs_snk_fin;
    sa = $urandom;
    da = $urandom;
    beats = (n + PPB - 1) / PPB;
    if (beats == 0) begin
      ts = -1;
      tf = 1;
    end else begin
      ts = 2 + imax(rs, rk);
      tf = ts + imax(sd, kd) + 1;
      exp_q.push_back(32'(tf - ts + 1));
    end
    exp_src = '0;
    exp_src.base_addr   = sa;
    exp_src.trans_size  = 32'(beats);
    exp_src.line_length = 16'(beats);
    exp_src.feat_length = 16'd1;
    exp_snk = exp_src;
    exp_snk.base_addr   = da;
    obs_src_req = 0; obs_snk_req = 0; obs_ts = -1; obs_tf = -1; busy_err = 0;
    obs_src_st = '0; obs_snk_st = '0; obs_src_fin = '0; obs_snk_fin = '0; obs_cyc = '0;

    for (int t = 0; t <= tf + 1; t++) begin
      start_i    = (t == 0) || (restart && ts > 0 && t == ts + 1);
      n_pixels_i = (t == 0) ? 16'(n) : 16'(n + 40);
      src_addr_i = (t == 0) ? sa : ~sa;
      dst_addr_i = (t == 0) ? da : ~da;
      src_flags.ready_start = (t >= 1 + rs);
      snk_flags.ready_start = (t >= 1 + rk);
      src_flags.done        = (ts > 0) && (t == ts + sd);
      snk_flags.done        = (ts > 0) && (t == ts + kd);
      if (src_ctrl.req_start) begin
        obs_src_req++;
        obs_ts     = t;
        obs_src_st = src_ctrl.addressgen_ctrl;
      end
      if (snk_ctrl.req_start) begin
        obs_snk_req++;
        obs_snk_st = snk_ctrl.addressgen_ctrl;
      end
      if (done_o && obs_tf < 0) obs_tf = t;
      if (t == tf) begin
        obs_src_fin = src_ctrl.addressgen_ctrl;
        obs_snk_fin = snk_ctrl.addressgen_ctrl;
      end
      if (t == tf + 1) obs_cyc = cycles_o;
      if (busy_o !== ((t >= 1) && (t <= tf))) busy_err++;
      step();
    end
    drive_idle();

    n_checks++;
    if (obs_src_req !== ((beats > 0) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s src_req_pulses: got %0d expected %0d", tag, obs_src_req, (beats > 0) ? 1 : 0);
    end
    n_checks++;
    if (obs_snk_req !== ((beats > 0) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s snk_req_pulses: got %0d expected %0d", tag, obs_snk_req, (beats > 0) ? 1 : 0);
    end
    n_checks++;
    if (obs_tf !== tf) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d expected %0d", tag, obs_tf, tf);
    end
    n_checks++;
    if (busy_err !== 0) begin
      n_fail++;
      $display("FAIL %s busy_profile: got %0d wrong cycles expected 0", tag, busy_err);
    end
    n_checks++;
    if (obs_src_fin !== exp_src) begin
      n_fail++;
      $display("FAIL %s src_cfg_held: got %h expected %h", tag, obs_src_fin, exp_src);
    end
    n_checks++;
    if (obs_snk_fin !== exp_snk) begin
      n_fail++;
      $display("FAIL %s snk_cfg_held: got %h expected %h", tag, obs_snk_fin, exp_snk);
    end
    if (beats > 0) begin
      exp_cyc = exp_q.pop_front();
      last_cycles = exp_cyc;
      n_checks++;
      if (obs_ts !== ts) begin
        n_fail++;
        $display("FAIL %s req_start_cycle: got %0d expected %0d", tag, obs_ts, ts);
      end
      n_checks++;
      if (obs_src_st !== exp_src) begin
        n_fail++;
        $display("FAIL %s src_cfg_start: got %h expected %h", tag, obs_src_st, exp_src);
      end
      n_checks++;
      if (obs_snk_st !== exp_snk) begin
        n_fail++;
        $display("FAIL %s snk_cfg_start: got %h expected %h", tag, obs_snk_st, exp_snk);
      end
      n_checks++;
      if (obs_cyc !== exp_cyc) begin
        n_fail++;
        $display("FAIL %s cycles_o: got %0d expected %0d", tag, obs_cyc, exp_cyc);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    drive_idle();
    repeat (3) step();
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset busy_o: got %b expected 0", busy_o); end
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset done_o: got %b expected 0", done_o); end
    n_checks++;
    if (cycles_o !== 32'd0) begin n_fail++; $display("FAIL reset cycles_o: got %0d expected 0", cycles_o); end
    n_checks++;
    if (src_ctrl !== '0) begin n_fail++; $display("FAIL reset src_ctrl: got %h expected 0", src_ctrl); end
    n_checks++;
    if (snk_ctrl !== '0) begin n_fail++; $display("FAIL reset snk_ctrl: got %h expected 0", snk_ctrl); end
    n_checks++;
    if (state_o !== IDLE) begin n_fail++; $display("FAIL reset state: got %0d expected %0d", state_o, IDLE); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_basic_job();
    run_job(8, 0, 0, 5, 9, 1'b0, "basic_8px");
  endtask

  task automatic test_beat_counts();
    run_job(5, 0, 0, 1, 2, 1'b0, "beats_5px");
    run_job(4, 0, 0, 2, 1, 1'b0, "beats_4px");
    run_job(1, 0, 0, 1, 1, 1'b0, "beats_1px");
    run_job(65535, 1, 0, 3, 2, 1'b0, "beats_max");
  endtask

  task automatic test_zero_pixels();
    run_job(0, 0, 0, 1, 1, 1'b0, "zero_px");
  endtask

  task automatic test_wait_ready();
    run_job(16, 0, 3, 2, 3, 1'b0, "sink_not_ready");
    run_job(16, 2, 1, 3, 2, 1'b0, "src_not_ready");
  endtask

  task automatic test_same_done_restart();
    run_job(20, 0, 0, 4, 4, 1'b1, "same_done_restart");
  endtask

  task automatic test_clear_priority();
    start_i    = 1'b1;
    clear_i    = 1'b1;
    n_pixels_i = 16'd12;
    step();
    drive_idle();
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clear_vs_start busy_o: got %b expected 0", busy_o); end
    n_checks++;
    if (cycles_o !== last_cycles) begin n_fail++; $display("FAIL clear_vs_start cycles_o: got %0d expected %0d", cycles_o, last_cycles); end
    step();
  endtask

  // Brings a 12-pixel job into RUN (cycle 3 after start_i).
  task automatic enter_run(input string tag);
    start_i    = 1'b1;
    n_pixels_i = 16'd12;
    src_addr_i = $urandom;
    dst_addr_i = $urandom;
    step();
    start_i = 1'b0;
    src_flags.ready_start = 1'b1;
    snk_flags.ready_start = 1'b1;
    step();
    step();
    n_checks++;
    if (state_o !== RUN) begin n_fail++; $display("FAIL %s reach_run: got %0d expected %0d", tag, state_o, RUN); end
  endtask

  task automatic expect_quiet(input string tag);
    int done_cnt, busy_cnt;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      src_flags.done = i[0];
      snk_flags.done = 1'b1;
      src_flags.ready_start = 1'b1;
      snk_flags.ready_start = 1'b1;
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
      step();
    end
    drive_idle();
    n_checks++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL %s late_done: got %0d pulses expected 0", tag, done_cnt); end
    n_checks++;
    if (busy_cnt !== 0) begin n_fail++; $display("FAIL %s late_busy: got %0d cycles expected 0", tag, busy_cnt); end
  endtask

  task automatic test_clear_abort();
    enter_run("clear_abort");
    clear_i        = 1'b1;
    src_flags.done = 1'b1;
    snk_flags.done = 1'b1;
    step();
    drive_idle();
    n_checks++;
    if (state_o !== IDLE) begin n_fail++; $display("FAIL clear_abort state: got %0d expected %0d", state_o, IDLE); end
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_abort busy_done: got %b%b expected 00", busy_o, done_o);
    end
    n_checks++;
    if (cycles_o !== last_cycles) begin n_fail++; $display("FAIL clear_abort cycles_kept: got %0d expected %0d", cycles_o, last_cycles); end
    expect_quiet("clear_abort");
    run_job(24, 0, 1, 2, 5, 1'b0, "after_clear");
  endtask

  task automatic test_reset_abort();
    enter_run("reset_abort");
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort busy_done: got %b%b expected 00", busy_o, done_o);
    end
    n_checks++;
    if (cycles_o !== 32'd0) begin n_fail++; $display("FAIL reset_abort cycles_o: got %0d expected 0", cycles_o); end
    n_checks++;
    if (src_ctrl !== '0 || snk_ctrl !== '0) begin
      n_fail++; $display("FAIL reset_abort ctrl: got %h %h expected 0", src_ctrl, snk_ctrl);
    end
    #1;
    rst_ni = 1'b1;
    last_cycles = 32'd0;
    step();
    expect_quiet("reset_abort");
    run_job(9, 1, 1, 6, 2, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_job(12, 0, 0, 1, 1, 1'b0, "b2b_0");
    run_job(0, 0, 0, 1, 1, 1'b0, "b2b_1");
    run_job(7, 0, 0, 3, 1, 1'b1, "b2b_2");
  endtask

  task automatic test_random();
    int n;
    for (int j = 0; j < 25; j++) begin
      if ($urandom_range(0, 7) == 0) n = 65535 - $urandom_range(0, 5);
      else                          n = $urandom_range(0, 200);
      run_job(n, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 12),
              $urandom_range(1, 12), 1'($urandom_range(0, 1)), $sformatf("rand_%0d", j));
    end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_beat_counts();
    test_zero_pixels();
    test_wait_ready();
    test_same_done_restart();
    test_clear_priority();
    test_clear_abort();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
